// File: rtl/err_log_pkg.sv
// Shared constants, entry layout and helpers for the error event logger.
package err_log_pkg;

   localparam int unsigned ERRSIG_ID_num = 7;
   localparam int unsigned TS_W          = 32;
   localparam int unsigned CNT_W         = 16;
   localparam int unsigned SEL_W         = $clog2(ERRSIG_ID_num);

   localparam int unsigned ENTRY_TS_LSB  = 0;
   localparam int unsigned ENTRY_A_LSB   = ENTRY_TS_LSB + TS_W;
   localparam int unsigned ENTRY_B_LSB   = ENTRY_A_LSB + ERRSIG_ID_num;
   localparam int unsigned ENTRY_W       = ENTRY_B_LSB + ERRSIG_ID_num;

   localparam logic [CNT_W-1:0] CNT_MAX  = 16'hFFFF;

   typedef logic [ERRSIG_ID_num-1:0] err_vec_t;

   typedef struct packed {
      err_vec_t        edge_b;
      err_vec_t        edge_a;
      logic [TS_W-1:0] ts;
   } err_entry_t;

   // Saturating increment shared by all 16-bit counters
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/err_log_fifo.sv
// Single-clock first-word-fall-through FIFO with registered head, flags and level.
module err_log_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 64
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         din,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_nxt;
   logic [LW-1:0]    level_d;
   logic             wr_ok;
   logic             rd_ok;

   // A full FIFO still accepts a write when the head is popped in the same cycle
   always_comb begin
      rd_ok   = rd_en && !empty;
      wr_ok   = wr_en && (!full || rd_en);
      rd_nxt  = rd_ptr + AW'(1);
      level_d = level;
      if (wr_ok && !rd_ok) begin
         level_d = level + LW'(1);
      end else if (rd_ok && !wr_ok) begin
         level_d = level - LW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
         dout   <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_nxt;
         end
         level <= level_d;
         empty <= (level_d == '0);
         full  <= (level_d == LW'(DEPTH));
         // Head register: bypass din into an empty/draining FIFO, else prefetch next slot
         if (wr_ok && (empty || (rd_ok && level == LW'(1)))) begin
            dout <= din;
         end else if (rd_ok && level > LW'(1)) begin
            dout <= mem[rd_nxt];
         end
      end
   end

endmodule

// File: rtl/err_event_logger.sv
// Timestamped rising-edge logger for the duplicated error vectors, with per-ID counters.
// Optional A/B disagreement detection is built when ERR_LOG_MISMATCH_EN is defined.
module err_event_logger
   import err_log_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 64
`ifdef ERR_LOG_MISMATCH_EN
 , parameter int unsigned MISMATCH_WIN = 16
`endif
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [ERRSIG_ID_num-1:0]      error_A,
   input  logic [ERRSIG_ID_num-1:0]      error_B,
   input  logic                          i_ts_clr,
   input  logic                          i_cnt_clr,
   input  logic                          i_rd_en,
   output logic [ENTRY_W-1:0]            o_rd_data,
   output logic                          o_empty,
   output logic                          o_full,
   output logic [$clog2(FIFO_DEPTH):0]   o_level,
   output logic [CNT_W-1:0]              o_ovf_cnt,
   input  logic [SEL_W-1:0]              i_cnt_sel,
   output logic [CNT_W-1:0]              o_cnt_A,
   output logic [CNT_W-1:0]              o_cnt_B,
   output logic [ERRSIG_ID_num-1:0]      o_mismatch
);

   err_vec_t                              err_a_d;
   err_vec_t                              err_b_d;
   err_vec_t                              edge_a;
   err_vec_t                              edge_b;
   logic [TS_W-1:0]                       ts_q;
   err_entry_t                            entry_d;
   err_entry_t                            entry_q;
   logic                                  entry_vld_q;
   logic                                  drop;
   logic [CNT_W-1:0]                      ovf_d;
   logic [ERRSIG_ID_num-1:0][CNT_W-1:0]   cnt_a_q;
   logic [ERRSIG_ID_num-1:0][CNT_W-1:0]   cnt_b_q;
   logic [ERRSIG_ID_num-1:0][CNT_W-1:0]   cnt_a_d;
   logic [ERRSIG_ID_num-1:0][CNT_W-1:0]   cnt_b_d;
   logic [CNT_W-1:0]                      cnt_a_sel;
   logic [CNT_W-1:0]                      cnt_b_sel;

   // Edge detect, entry build and overflow accounting
   always_comb begin
      edge_a         = error_A & ~err_a_d;
      edge_b         = error_B & ~err_b_d;
      entry_d.edge_b = edge_b;
      entry_d.edge_a = edge_a;
      entry_d.ts     = ts_q;
      drop           = entry_vld_q && o_full && !i_rd_en;
      ovf_d          = o_ovf_cnt;
      if (i_cnt_clr) begin
         ovf_d = '0;
      end else if (drop) begin
         ovf_d = sat_inc(o_ovf_cnt);
      end
   end

   // Per-ID counters; clear takes priority over a coincident edge
   always_comb begin
      cnt_a_sel = '0;
      cnt_b_sel = '0;
      for (int i = 0; i < ERRSIG_ID_num; i++) begin
         cnt_a_d[i] = cnt_a_q[i];
         cnt_b_d[i] = cnt_b_q[i];
         if (i_cnt_clr) begin
            cnt_a_d[i] = '0;
            cnt_b_d[i] = '0;
         end else begin
            if (edge_a[i]) begin
               cnt_a_d[i] = sat_inc(cnt_a_q[i]);
            end
            if (edge_b[i]) begin
               cnt_b_d[i] = sat_inc(cnt_b_q[i]);
            end
         end
         if (i_cnt_sel == SEL_W'(i)) begin
            cnt_a_sel = cnt_a_q[i];
            cnt_b_sel = cnt_b_q[i];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ts_q        <= '0;
         err_a_d     <= '0;
         err_b_d     <= '0;
         entry_q     <= '0;
         entry_vld_q <= 1'b0;
         cnt_a_q     <= '0;
         cnt_b_q     <= '0;
         o_ovf_cnt   <= '0;
         o_cnt_A     <= '0;
         o_cnt_B     <= '0;
      end else begin
         ts_q        <= i_ts_clr ? '0 : ts_q + TS_W'(1);
         err_a_d     <= error_A;
         err_b_d     <= error_B;
         entry_q     <= entry_d;
         entry_vld_q <= |{edge_a, edge_b};
         cnt_a_q     <= cnt_a_d;
         cnt_b_q     <= cnt_b_d;
         o_ovf_cnt   <= ovf_d;
         o_cnt_A     <= cnt_a_sel;
         o_cnt_B     <= cnt_b_sel;
      end
   end

   err_log_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .wr_en (entry_vld_q),
      .din   (entry_q),
      .rd_en (i_rd_en),
      .dout  (o_rd_data),
      .empty (o_empty),
      .full  (o_full),
      .level (o_level)
   );

`ifdef ERR_LOG_MISMATCH_EN
   localparam int unsigned MM_W = $clog2(MISMATCH_WIN + 1);

   logic [ERRSIG_ID_num-1:0][MM_W-1:0] mm_cnt_q;
   logic [ERRSIG_ID_num-1:0][MM_W-1:0] mm_cnt_d;
   err_vec_t                           mm_flag_d;

   // Run-length of A/B disagreement per ID; flag is sticky once the window is reached
   always_comb begin
      for (int i = 0; i < ERRSIG_ID_num; i++) begin
         mm_cnt_d[i]  = '0;
         mm_flag_d[i] = o_mismatch[i];
         if (i_cnt_clr) begin
            mm_flag_d[i] = 1'b0;
         end else if (error_A[i] != error_B[i]) begin
            mm_cnt_d[i] = (mm_cnt_q[i] == MM_W'(MISMATCH_WIN)) ? mm_cnt_q[i]
                                                              : mm_cnt_q[i] + MM_W'(1);
            if (mm_cnt_d[i] == MM_W'(MISMATCH_WIN)) begin
               mm_flag_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mm_cnt_q   <= '0;
         o_mismatch <= '0;
      end else begin
         mm_cnt_q   <= mm_cnt_d;
         o_mismatch <= mm_flag_d;
      end
   end
`else
   assign o_mismatch = '0;
`endif

endmodule

// File: tb/tb_err_event_logger.sv
// Directed self-checking bench for err_event_logger.
`timescale 1ns/1ps
module tb_err_event_logger;
   import err_log_pkg::*;

`ifdef ERR_LOG_MISMATCH_EN
   localparam logic [6:0] MM_SET = 7'h08;
`else
   localparam logic [6:0] MM_SET = 7'h00;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  err_a;
   logic [6:0]  err_b;
   logic        ts_clr;
   logic        cnt_clr;
   logic        rd_en;
   logic [45:0] rd_data;
   logic        empty;
   logic        full;
   logic [6:0]  level;
   logic [15:0] ovf_cnt;
   logic [2:0]  cnt_sel;
   logic [15:0] cnt_a;
   logic [15:0] cnt_b;
   logic [6:0]  mismatch;

   logic [6:0][15:0] cnt_force;
   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   err_event_logger dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .error_A    (err_a),
      .error_B    (err_b),
      .i_ts_clr   (ts_clr),
      .i_cnt_clr  (cnt_clr),
      .i_rd_en    (rd_en),
      .o_rd_data  (rd_data),
      .o_empty    (empty),
      .o_full     (full),
      .o_level    (level),
      .o_ovf_cnt  (ovf_cnt),
      .i_cnt_sel  (cnt_sel),
      .o_cnt_A    (cnt_a),
      .o_cnt_B    (cnt_b),
      .o_mismatch (mismatch)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [45:0] mk_entry(input logic [6:0] b, input logic [6:0] a,
                                            input logic [31:0] ts);
      return {b, a, ts};
   endfunction

   task automatic pulse_a(input logic [6:0] v);
      err_a = v;
      tick();
      err_a = '0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; err_a = '0; err_b = '0; ts_clr = 1'b0; cnt_clr = 1'b0;
      rd_en = 1'b0; cnt_sel = '0;
      tick(3);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_full", 64'(full), 64'd0);
      check("rst_level", 64'(level), 64'd0);
      check("rst_ovf", 64'(ovf_cnt), 64'd0);
      check("rst_data", 64'(rd_data), 64'd0);
      check("rst_cnt_a", 64'(cnt_a), 64'd0);
      check("rst_mismatch", 64'(mismatch), 64'd0);
      rst = 1'b0;

      // 1: single edge at ts=100
      ts_clr = 1'b1;
      tick();
      ts_clr = 1'b0;
      tick(100);
      err_a = 7'h01;
      tick();
      err_a = '0;
      check("t1_empty_t1", 64'(empty), 64'd1);
      tick();
      check("t1_empty_t2", 64'(empty), 64'd0);
      check("t1_entry", 64'(rd_data), 64'(mk_entry(7'h00, 7'h01, 32'd100)));
      check("t1_level", 64'(level), 64'd1);
      check("t1_cnt_a0", 64'(cnt_a), 64'd1);
      rd_en = 1'b1;
      tick();
      check("t1_pop_empty", 64'(empty), 64'd1);
      tick();
      rd_en = 1'b0;
      check("t1_underflow_level", 64'(level), 64'd0);
      check("t1_underflow_empty", 64'(empty), 64'd1);

      // 2: coincident edges on both copies make one entry
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      err_a = 7'h05;
      err_b = 7'h04;
      tick();
      err_a = '0;
      err_b = '0;
      tick();
      check("t2_edges", 64'(rd_data[45:32]), 64'({7'h04, 7'h05}));
      check("t2_cnt_a0", 64'(cnt_a), 64'd1);
      check("t2_cnt_b0", 64'(cnt_b), 64'd0);
      cnt_sel = 3'd2;
      tick();
      check("t2_cnt_a2", 64'(cnt_a), 64'd1);
      check("t2_cnt_b2", 64'(cnt_b), 64'd1);
      tick(2);
      check("t2_one_entry", 64'(level), 64'd1);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("t2_drained", 64'(empty), 64'd1);

      // 3: fill, overflow, then write accepted alongside a pop when full
      cnt_sel = 3'd0;
      for (int k = 0; k < 64; k++) pulse_a(7'h01);
      check("t3_full64", 64'(full), 64'd1);
      check("t3_level64", 64'(level), 64'd64);
      check("t3_ovf0", 64'(ovf_cnt), 64'd0);
      for (int k = 0; k < 3; k++) pulse_a(7'h01);
      tick(2);
      check("t3_ovf3", 64'(ovf_cnt), 64'd3);
      check("t3_level_hold", 64'(level), 64'd64);
      check("t3_cnt_indep", 64'(cnt_a), 64'd68);
      err_a = 7'h01;
      tick();
      err_a = '0;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      tick();
      check("t3_rdwr_level", 64'(level), 64'd64);
      check("t3_rdwr_ovf", 64'(ovf_cnt), 64'd3);
      check("t3_rdwr_full", 64'(full), 64'd1);
      do_reset();
      check("t3_rst_empty", 64'(empty), 64'd1);
      check("t3_rst_level", 64'(level), 64'd0);
      check("t3_rst_ovf", 64'(ovf_cnt), 64'd0);
      tick();
      check("t3_rst_cnt", 64'(cnt_a), 64'd0);

      // 4: counter saturation, clear priority, out-of-range select
      cnt_force    = '0;
      cnt_force[0] = 16'hFFFE;
      force dut.cnt_a_q = cnt_force;
      #2;
      release dut.cnt_a_q;
      for (int k = 0; k < 3; k++) pulse_a(7'h01);
      tick();
      check("t4_sat", 64'(cnt_a), 64'hFFFF);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      tick(2);
      check("t4_clr", 64'(cnt_a), 64'd0);
      err_a = 7'h01;
      cnt_clr = 1'b1;
      tick();
      err_a = '0;
      cnt_clr = 1'b0;
      tick(2);
      check("t4_clr_wins", 64'(cnt_a), 64'd0);
      pulse_a(7'h01);
      tick();
      check("t4_cnt_one", 64'(cnt_a), 64'd1);
      cnt_sel = 3'd7;
      tick();
      check("t4_sel7", 64'(cnt_a), 64'd0);
      cnt_sel = 3'd0;

      // 5: timestamp wrap and clear
      do_reset();
      force dut.ts_q = 32'hFFFF_FFFF;
      err_a = 7'h01;
      #2;
      release dut.ts_q;
      tick();
      err_a = 7'h03;
      tick();
      err_a = '0;
      tick(2);
      check("t5_level2", 64'(level), 64'd2);
      check("t5_ts_max", 64'(rd_data), 64'(mk_entry(7'h00, 7'h01, 32'hFFFF_FFFF)));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("t5_ts_wrap", 64'(rd_data), 64'(mk_entry(7'h00, 7'h02, 32'h0)));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("t5_drained", 64'(empty), 64'd1);
      ts_clr = 1'b1;
      tick();
      ts_clr = 1'b0;
      err_a = 7'h04;
      tick();
      err_a = '0;
      tick();
      check("t5_ts_clr", 64'(rd_data), 64'(mk_entry(7'h00, 7'h04, 32'h0)));

      // 6: A/B disagreement window
      do_reset();
      err_a = 7'h08;
      err_b = 7'h00;
      tick(15);
      check("t6_mm_15", 64'(mismatch), 64'd0);
      tick();
      check("t6_mm_16", 64'(mismatch), 64'(MM_SET));
      err_a = '0;
      tick(3);
      check("t6_mm_sticky", 64'(mismatch), 64'(MM_SET));
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("t6_mm_clr", 64'(mismatch), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
